// File: rtl/if_prefetch_stage_pkg.sv
// Shared widths, constants and types for the instruction-fetch prefetch stage.
package if_prefetch_stage_pkg;

  localparam int IF_ADDR_W = 32;
  localparam int IF_INST_W = 32;
  localparam int PC_STEP   = 4;

  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_DROP,
    RESP_KEEP
  } resp_action_e;

endpackage

// File: rtl/if_prefetch_stage_sync_fifo.sv
// Synchronous FIFO with flush and occupancy count; first-word-fall-through read port.
module if_prefetch_stage_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: in-order pipelined fetch requests, prefetch buffering and
// redirect flush with discard of responses that belong to the pre-redirect stream.
module if_prefetch_stage
  import if_prefetch_stage_pkg::*;
#(
  parameter int                ADDR_W     = IF_ADDR_W,
  parameter int                INST_W     = IF_INST_W,
  parameter int                FIFO_DEPTH = 4,
  parameter int                MAX_OUTST  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_pc,
  input  logic                     id_allow_in,
  output logic                     if_to_id_valid,
  output logic [INST_W+ADDR_W-1:0] if_to_id_bus,
  output logic                     inst_req_valid,
  input  logic                     inst_req_ready,
  output logic [ADDR_W-1:0]        inst_req_addr,
  input  logic                     inst_valid,
  output logic                     inst_ready,
  input  logic [INST_W-1:0]        inst_data,
  input  logic                     mem_busy
);

  localparam int BUS_W  = INST_W + ADDR_W;
  localparam int OUT_W  = $clog2(MAX_OUTST + 1);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W  = FCNT_W + 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] tag_pc;
  logic [OUT_W-1:0]  outst;
  logic [OUT_W-1:0]  outst_retired;
  logic [OUT_W-1:0]  drop_cnt;
  logic [FCNT_W-1:0] fifo_count;
  logic [SUM_W-1:0]  reserved;
  logic              fifo_empty;
  logic              unused_fifo_full;
  logic              tag_full;
  logic              tag_empty;
  logic              req_fire;
  logic              resp;
  logic              id_pop;
  resp_action_e      resp_action;

  // Buffer space is claimed at issue time, so every in-flight response already owns a slot.
  assign reserved       = SUM_W'(outst) + SUM_W'(fifo_count);
  assign inst_req_valid = ~rst & ~redirect_valid & ~mem_busy & ~tag_full
                        & (reserved < SUM_W'(FIFO_DEPTH));
  assign inst_req_addr  = fetch_pc;
  assign req_fire       = inst_req_valid & inst_req_ready;

  assign inst_ready     = ~rst;
  assign resp           = inst_valid & inst_ready & ~tag_empty;
  assign outst_retired  = outst - OUT_W'(resp);

  assign if_to_id_valid = ~rst & ~fifo_empty & ~redirect_valid;
  assign id_pop         = if_to_id_valid & id_allow_in;

  always_comb begin
    resp_action = RESP_NONE;
    if (resp) begin
      resp_action = (redirect_valid || drop_cnt != '0) ? RESP_DROP : RESP_KEEP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      // Everything still outstanding after this cycle belongs to the abandoned stream.
      fetch_pc <= redirect_pc;
      drop_cnt <= outst_retired;
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
      end
      if (resp_action == RESP_DROP) begin
        drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  // Tag queue occupancy doubles as the in-flight request count.
  if_prefetch_stage_sync_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (MAX_OUTST)
  ) u_tag_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (resp),
    .pop_data  (tag_pc),
    .flush     (1'b0),
    .count     (outst),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  if_prefetch_stage_sync_fifo #(
    .WIDTH (BUS_W),
    .DEPTH (FIFO_DEPTH)
  ) u_prefetch_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (resp_action == RESP_KEEP),
    .push_data ({inst_data, tag_pc}),
    .pop       (id_pop),
    .pop_data  (if_to_id_bus),
    .flush     (redirect_valid),
    .count     (fifo_count),
    .full      (unused_fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed then randomized bench for if_prefetch_stage against a stream/epoch reference model.
module tb_if_prefetch_stage;

  localparam int ADDR_W     = 32;
  localparam int INST_W     = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int MAX_OUTST  = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     redirect_valid;
  logic [ADDR_W-1:0]        redirect_pc;
  logic                     id_allow_in;
  logic                     if_to_id_valid;
  logic [INST_W+ADDR_W-1:0] if_to_id_bus;
  logic                     inst_req_valid;
  logic                     inst_req_ready;
  logic [ADDR_W-1:0]        inst_req_addr;
  logic                     inst_valid;
  logic                     inst_ready;
  logic [INST_W-1:0]        inst_data;
  logic                     mem_busy;

  always #5 clk = ~clk;

  if_prefetch_stage #(
    .ADDR_W     (ADDR_W),
    .INST_W     (INST_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .MAX_OUTST  (MAX_OUTST),
    .RESET_PC   (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_allow_in    (id_allow_in),
    .if_to_id_valid (if_to_id_valid),
    .if_to_id_bus   (if_to_id_bus),
    .inst_req_valid (inst_req_valid),
    .inst_req_ready (inst_req_ready),
    .inst_req_addr  (inst_req_addr),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .mem_busy       (mem_busy)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int unsigned       due;
    int unsigned       epoch;
  } mreq_t;

  mreq_t             mq[$];     // requests accepted by memory, in order
  logic [ADDR_W-1:0] buf_q[$];  // pcs of current-stream instructions waiting for ID
  logic [ADDR_W-1:0] req_pc;
  int unsigned       epoch;
  int unsigned       cyc;
  int unsigned       lat_min;
  int unsigned       lat_max;
  int unsigned       delivered;
  int                checks;
  int                failures;

  function automatic logic [INST_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_5A5A;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic redir, input logic [ADDR_W-1:0] rpc,
                       input logic allow, input logic rdy, input logic busy);
    logic        exp_req;
    logic        exp_id;
    int unsigned inflight;
    mreq_t       m;
    @(negedge clk);
    rst            = r;
    redirect_valid = redir;
    redirect_pc    = rpc;
    id_allow_in    = allow;
    inst_req_ready = rdy;
    mem_busy       = busy;
    if (!r && mq.size() > 0 && mq[0].due <= cyc) begin
      inst_valid = 1'b1;
      inst_data  = mem_word(mq[0].addr);
    end else begin
      inst_valid = 1'b0;
      inst_data  = $urandom;
    end
    #1;
    inflight = mq.size();
    exp_req  = !r && !redir && !busy && inflight < MAX_OUTST
               && inflight + buf_q.size() < FIFO_DEPTH;
    exp_id   = !r && !redir && buf_q.size() > 0;
    check("inst_ready", 64'(inst_ready), 64'(!r));
    check("req_valid", 64'(inst_req_valid), 64'(exp_req));
    if (exp_req) check("req_addr", 64'(inst_req_addr), 64'(req_pc));
    check("id_valid", 64'(if_to_id_valid), 64'(exp_id));
    if (r) begin
      mq.delete();
      buf_q.delete();
      epoch++;
      req_pc = '0;
    end else begin
      if (exp_id && allow) begin
        check("id_bus", if_to_id_bus, {mem_word(buf_q[0]), buf_q[0]});
        void'(buf_q.pop_front());
        delivered++;
      end
      if (inst_valid) begin
        m = mq.pop_front();
        if (!redir && m.epoch == epoch) buf_q.push_back(m.addr);
      end
      if (exp_req && rdy) begin
        mq.push_back('{addr: req_pc, due: cyc + $urandom_range(lat_max, lat_min), epoch: epoch});
        req_pc += 32'd4;
      end
      if (redir) begin
        buf_q.delete();
        epoch++;
        req_pc = rpc;
      end
    end
    cyc++;
  endtask

  initial begin
    logic [ADDR_W-1:0] rpc;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; id_allow_in = 1'b0;
    inst_req_ready = 1'b0; inst_valid = 1'b0; inst_data = '0; mem_busy = 1'b0;
    checks = 0; failures = 0; epoch = 0; cyc = 0; delivered = 0; req_pc = '0;
    lat_min = 1; lat_max = 1;

    repeat (3) cycle(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    // 1-cycle memory, ID always ready: steady stream from pc 0.
    repeat (12) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("stream_started", 64'(delivered >= 4), 64'd1);
    // ID stalled for 10 cycles: buffer fills to depth and requests stop.
    repeat (10) cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("stall_req_low", 64'(inst_req_valid), 64'd0);
    repeat (8) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    // 3-cycle memory: two requests in flight.
    lat_min = 3; lat_max = 3;
    repeat (15) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    // Build a backlog, then redirect with responses still in flight.
    repeat (5) cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 1'b0);
    repeat (12) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    // Redirect coinciding with a response and an un-accepted request.
    lat_min = 1; lat_max = 1;
    repeat (6) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 1'b0);
    repeat (8) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    // mem_busy held for 5 cycles with 2-cycle memory.
    lat_min = 2; lat_max = 2;
    repeat (4) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    repeat (5) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    repeat (8) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    // Address wrap-around.
    cycle(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1, 1'b0);
    repeat (10) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);

    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      cycle($urandom_range(0, 499) == 0, $urandom_range(0, 29) == 0, rpc,
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 9) == 0);
    end
    repeat (20) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
